// File: rtl/mcc_pkg.sv
// ============================================================================
// Module : mcc_pkg
// Brief  : Shared types and constants for the multicycle RV32I controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_FWAIT  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_MWAIT  = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } class_e;

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;

  localparam logic [1:0] c_rdv_pc4 = 2'b00;
  localparam logic [1:0] c_rdv_alu = 2'b01;
  localparam logic [1:0] c_rdv_imm = 2'b10;
  localparam logic [1:0] c_rdv_mem = 2'b11;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module : multicycle_controller_if
// Brief  : Controller <-> datapath bundle: opcode/branch in, enables and selects out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        pc_write;
  logic        sel_pc;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic        sel_alu_op1;
  logic        sel_alu_op2;
  logic [1:0]  sel_rdv;
  logic        sel_addr;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instret;

  modport master (
    input  opcode, branch_taken,
    output pc_write, sel_pc, ir_write, reg_write, mem_write,
           sel_alu_op1, sel_alu_op2, sel_rdv, sel_addr, state, halted, instret
  );

  modport slave (
    output opcode, branch_taken,
    input  pc_write, sel_pc, ir_write, reg_write, mem_write,
           sel_alu_op1, sel_alu_op2, sel_rdv, sel_addr, state, halted, instret
  );
endinterface

`default_nettype wire

// File: rtl/mcc_decode.sv
// ============================================================================
// Module : mcc_decode
// Brief  : Combinational RV32I opcode-to-instruction-class map.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcc_decode
  import mcc_pkg::*;
(
  input  logic [6:0] i_opcode,
  output class_e     o_class
);

  always_comb begin
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      c_opc_op:     o_class = CLS_ALU_R;
      c_opc_op_imm: o_class = CLS_ALU_I;
      c_opc_load:   o_class = CLS_LOAD;
      c_opc_store:  o_class = CLS_STORE;
      c_opc_branch: o_class = CLS_BRANCH;
      c_opc_jal:    o_class = CLS_JAL;
      c_opc_jalr:   o_class = CLS_JALR;
      c_opc_lui:    o_class = CLS_LUI;
      c_opc_auipc:  o_class = CLS_AUIPC;
      default:      o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module : multicycle_controller
// Brief  : FETCH/FWAIT/DECODE/EXEC/MEM/MWAIT/WB sequencer for the multi-cycle
//          RV32I datapath, with retired-instruction counter.
//          Option MCC_ILLEGAL_HALT_EN: illegal opcode enters HALT (else NOP).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import mcc_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 1
)
(
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  localparam logic [2:0] c_wait_init = 3'(MEM_WAIT_CYCLES - 1);

  state_e      r_state;
  state_e      w_state_next;
  class_e      r_class;
  class_e      w_class_dec;
  logic [2:0]  r_wait_cnt;
  logic [2:0]  w_wait_next;
  logic [31:0] r_instret;

  logic        w_pc_write;
  logic        w_sel_pc;
  logic        w_ir_write;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_sel_alu_op1;
  logic        w_sel_alu_op2;
  logic [1:0]  w_sel_rdv;
  logic        w_sel_addr;
  logic        w_exec_phase;

  mcc_decode u_decode (
    .i_opcode (bus.opcode),
    .o_class  (w_class_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_class    <= CLS_ALU_R;
      r_wait_cnt <= 3'd0;
      r_instret  <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (r_state == ST_DECODE) begin
        r_class <= w_class_dec;
      end
      if (w_pc_write) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  // Operand/writeback selects stay stable across the whole execute phase.
  assign w_exec_phase = (r_state == ST_EXEC) || (r_state == ST_MEM) ||
                        (r_state == ST_MWAIT) || (r_state == ST_WB);

  always_comb begin
    w_state_next  = r_state;
    w_wait_next   = r_wait_cnt;
    w_pc_write    = 1'b0;
    w_sel_pc      = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_write   = 1'b0;
    w_sel_alu_op1 = 1'b0;
    w_sel_alu_op2 = 1'b0;
    w_sel_rdv     = c_rdv_pc4;
    w_sel_addr    = 1'b0;

    if (w_exec_phase) begin
      w_sel_alu_op1 = (r_class == CLS_ALU_R)  || (r_class == CLS_ALU_I) ||
                      (r_class == CLS_LOAD)   || (r_class == CLS_STORE) ||
                      (r_class == CLS_JALR)   || (r_class == CLS_BRANCH);
      w_sel_alu_op2 = (r_class == CLS_ALU_R)  || (r_class == CLS_BRANCH);
      w_sel_pc      = (r_class == CLS_JAL)    || (r_class == CLS_JALR);
      case (r_class)
        CLS_ALU_R, CLS_ALU_I, CLS_AUIPC: w_sel_rdv = c_rdv_alu;
        CLS_LOAD:                        w_sel_rdv = c_rdv_mem;
        CLS_LUI:                         w_sel_rdv = c_rdv_imm;
        default:                         w_sel_rdv = c_rdv_pc4;
      endcase
    end

    case (r_state)
      ST_FETCH: begin
        w_state_next = ST_FWAIT;
        w_wait_next  = c_wait_init;
      end
      ST_FWAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_ir_write   = 1'b1;
          w_state_next = ST_DECODE;
        end else begin
          w_wait_next = r_wait_cnt - 3'd1;
        end
      end
      ST_DECODE: begin
        w_state_next = ST_EXEC;
`ifdef MCC_ILLEGAL_HALT_EN
        if (w_class_dec == CLS_ILLEGAL) begin
          w_state_next = ST_HALT;
        end
`endif
      end
      ST_EXEC: begin
        case (r_class)
          CLS_BRANCH: begin
            w_pc_write   = 1'b1;
            w_sel_pc     = bus.branch_taken;
            w_state_next = ST_FETCH;
          end
          CLS_ILLEGAL: begin
            w_pc_write   = 1'b1;
            w_sel_pc     = 1'b0;
            w_state_next = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: w_state_next = ST_MEM;
          default:             w_state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_sel_addr = 1'b1;
        if (r_class == CLS_STORE) begin
          w_mem_write  = 1'b1;
          w_pc_write   = 1'b1;
          w_sel_pc     = 1'b0;
          w_state_next = ST_FETCH;
        end else begin
          w_wait_next  = c_wait_init;
          w_state_next = ST_MWAIT;
        end
      end
      ST_MWAIT: begin
        w_sel_addr = 1'b1;
        if (r_wait_cnt == 3'd0) begin
          w_state_next = ST_WB;
        end else begin
          w_wait_next = r_wait_cnt - 3'd1;
        end
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_HALT: begin
        w_state_next  = ST_HALT;
        w_sel_alu_op1 = 1'b0;
        w_sel_alu_op2 = 1'b0;
        w_sel_rdv     = c_rdv_pc4;
        w_sel_pc      = 1'b0;
      end
      default: w_state_next = ST_FETCH;
    endcase
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.sel_pc      = w_sel_pc;
  assign bus.ir_write    = w_ir_write;
  assign bus.reg_write   = w_reg_write;
  assign bus.mem_write   = w_mem_write;
  assign bus.sel_alu_op1 = w_sel_alu_op1;
  assign bus.sel_alu_op2 = w_sel_alu_op2;
  assign bus.sel_rdv     = w_sel_rdv;
  assign bus.sel_addr    = w_sel_addr;
  assign bus.state       = r_state;
  assign bus.instret     = r_instret;

`ifdef MCC_ILLEGAL_HALT_EN
  assign bus.halted = (r_state == ST_HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module : tb_multicycle_controller
// Brief  : Directed scoreboard bench for multicycle_controller.
//          Honours MCC_ILLEGAL_HALT_EN for the illegal-opcode step.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;
  import mcc_pkg::*;

  localparam int W = 2;

  typedef struct {
    string       name;
    int          cycles;
    logic        sel_pc;
    logic        reg_write;
    logic [1:0]  sel_rdv;
    logic        mem_write;
    logic        chk_ops;
    logic        op1;
    logic        op2;
    logic [31:0] instret;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   model_instret;
  exp_t sb[$];

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] out_vec();
    return {bus.pc_write, bus.sel_pc, bus.ir_write, bus.reg_write, bus.mem_write,
            bus.sel_alu_op1, bus.sel_alu_op2, bus.sel_rdv, bus.sel_addr};
  endfunction

  // Starts in FETCH, #1 after a rising edge; returns #1 after the edge following retire.
  task automatic run_instr(input string name, input logic [6:0] opc, input logic bt,
                           input int cyc, input logic spc, input logic rw,
                           input logic [1:0] rdv, input logic mw,
                           input logic chk_ops, input logic op1, input logic op2);
    exp_t e;
    int   k;
    int   irw;
    int   early_rw;
    int   mwc;
    bit   addr_ok;
    bit   done;
    model_instret++;
    e = '{name, cyc, spc, rw, rdv, mw, chk_ops, op1, op2, 32'(model_instret)};
    sb.push_back(e);
    bus.opcode       = opc;
    bus.branch_taken = bt;
    k = 1; irw = 0; early_rw = 0; mwc = 0; addr_ok = 1'b1; done = 1'b0;
    while (!done && k <= 40) begin
      if (bus.ir_write) irw++;
      if (bus.mem_write) mwc++;
      if (bus.sel_addr !== ((bus.state == ST_MEM) || (bus.state == ST_MWAIT))) addr_ok = 1'b0;
      if (bus.pc_write) begin
        done = 1'b1;
      end else begin
        if (bus.reg_write) early_rw++;
        // Scramble the opcode once decoded; class must already be latched.
        if (bus.state == ST_EXEC) bus.opcode = 7'h00;
        @(posedge clk); #1;
        k++;
      end
    end
    e = sb.pop_front();
    check({e.name, "_retire_seen"}, 32'(done), 32'd1);
    check({e.name, "_cycles"}, 32'(k), 32'(e.cycles));
    check({e.name, "_sel_pc"}, 32'(bus.sel_pc), 32'(e.sel_pc));
    check({e.name, "_reg_write"}, 32'(bus.reg_write), 32'(e.reg_write));
    check({e.name, "_mem_write"}, 32'(bus.mem_write), 32'(e.mem_write));
    check({e.name, "_mem_write_cnt"}, 32'(mwc), e.mem_write ? 32'd1 : 32'd0);
    check({e.name, "_ir_write_cnt"}, 32'(irw), 32'd1);
    check({e.name, "_early_reg_write"}, 32'(early_rw), 32'd0);
    check({e.name, "_sel_addr"}, 32'(addr_ok), 32'd1);
    if (e.reg_write) check({e.name, "_sel_rdv"}, 32'(bus.sel_rdv), 32'(e.sel_rdv));
    if (e.chk_ops) begin
      check({e.name, "_op1"}, 32'(bus.sel_alu_op1), 32'(e.op1));
      check({e.name, "_op2"}, 32'(bus.sel_alu_op2), 32'(e.op2));
    end
    @(posedge clk); #1;
    check({e.name, "_instret"}, bus.instret, e.instret);
    check({e.name, "_next_fetch"}, 32'(bus.state), 32'(ST_FETCH));
  endtask

  initial begin
    checks = 0; errors = 0; model_instret = 0;
    rst = 1'b1;
    bus.opcode = 7'h00;
    bus.branch_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(bus.state), 32'(ST_FETCH));
    check("reset_instret", bus.instret, 32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);
    check("reset_outputs", 32'(out_vec()), 32'd0);
    rst = 1'b0;

    run_instr("add",    7'b0110011, 1'b0, 4+W,   1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr("lw",     7'b0000011, 1'b0, 5+2*W, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr("beq_t",  7'b1100011, 1'b1, 3+W,   1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr("beq_nt", 7'b1100011, 1'b0, 3+W,   1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr("sw",     7'b0100011, 1'b0, 4+W,   1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    run_instr("jal",    7'b1101111, 1'b0, 4+W,   1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr("jalr",   7'b1100111, 1'b0, 4+W,   1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr("lui",    7'b0110111, 1'b0, 4+W,   1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("auipc",  7'b0010111, 1'b0, 4+W,   1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr("addi",   7'b0010011, 1'b0, 4+W,   1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an instruction fetch.
    bus.opcode = 7'b0110011;
    @(posedge clk); #1;
    check("mid_fwait_state", 32'(bus.state), 32'(ST_FWAIT));
    rst = 1'b1;
    #1;
    check("rst_async_state", 32'(bus.state), 32'(ST_FETCH));
    check("rst_async_instret", bus.instret, 32'd0);
    check("rst_async_outputs", 32'(out_vec()), 32'd0);
    model_instret = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_release_ir_write", 32'(bus.ir_write), 32'd0);
    run_instr("add_after_rst", 7'b0110011, 1'b0, 4+W, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);

`ifdef MCC_ILLEGAL_HALT_EN
    begin
      int k;
      int pcw;
      bus.opcode = 7'h00;
      k = 0;
      while (!bus.halted && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      check("halt_reached", 32'(bus.halted), 32'd1);
      check("halt_cycles", 32'(k), 32'(W + 2));
      check("halt_state", 32'(bus.state), 32'(ST_HALT));
      pcw = 0;
      for (int i = 0; i < 100; i++) begin
        bus.opcode = 7'(i);
        if (bus.pc_write || bus.reg_write || bus.mem_write || bus.ir_write) pcw++;
        @(posedge clk); #1;
      end
      check("halt_no_enables", 32'(pcw), 32'd0);
      check("halt_instret_frozen", bus.instret, 32'(model_instret));
      check("halt_still_halted", 32'(bus.halted), 32'd1);
    end
`else
    run_instr("illegal_nop", 7'h00, 1'b0, 3+W, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nop_halted", 32'(bus.halted), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
